// File: rtl/joystick_player_ctrl_if.sv
// Shot request handshake between the player controller and the bullet manager.
interface joystick_player_ctrl_if #(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 9
);
  logic           shoot_valid;
  logic           shoot_ready;
  logic [X_W-1:0] shoot_x;
  logic [Y_W-1:0] shoot_y;

  modport master (output shoot_valid, output shoot_x, output shoot_y, input shoot_ready);
  modport slave  (input shoot_valid, input shoot_x, input shoot_y, output shoot_ready);
endinterface

// File: rtl/joystick_player_ctrl.sv
// Player sprite controller: auto-repeat movement with edge clamping, and a
// shot request FSM (IDLE/REQ/COOL) with post-shot cooldown.
module joystick_player_ctrl #(
  parameter int unsigned X_W          = 10,
  parameter int unsigned Y_W          = 9,
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 639,
  parameter int unsigned Y_MIN        = 0,
  parameter int unsigned Y_MAX        = 479,
  parameter int unsigned X_INIT       = 320,
  parameter int unsigned Y_INIT       = 400,
  parameter int unsigned STEP         = 4,
  parameter int unsigned REPEAT_CYC   = 250000,
  parameter int unsigned COOLDOWN_CYC = 5000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_up,
  input  logic                    i_down,
  input  logic                    i_left,
  input  logic                    i_right,
  input  logic                    i_fire,
  input  logic                    i_game_run,
  input  logic                    i_respawn,
  output logic [X_W-1:0]          o_x,
  output logic [Y_W-1:0]          o_y,
  output logic                    o_moving,
  output logic                    o_cooldown,
  joystick_player_ctrl_if.master  shoot
);

  localparam int unsigned XE_W = X_W + 1;
  localparam int unsigned YE_W = Y_W + 1;
  localparam int unsigned RC_W = $clog2(REPEAT_CYC);
  localparam int unsigned CC_W = $clog2(COOLDOWN_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_COOL} shot_state_e;

  shot_state_e     shot_state;
  logic [RC_W-1:0] rep_cnt;
  logic [CC_W-1:0] cool_cnt;

  logic            right_c, left_c, down_c, up_c, active_c, move_c;
  logic [XE_W-1:0] x_ext_c, x_inc_c, x_dec_c;
  logic [YE_W-1:0] y_ext_c, y_inc_c, y_dec_c;
  logic [X_W-1:0]  x_next_c;
  logic [Y_W-1:0]  y_next_c;

  // Opposing directions cancel; clamped next position computed one bit wider.
  always_comb begin
    right_c  = i_right & ~i_left;
    left_c   = i_left & ~i_right;
    down_c   = i_down & ~i_up;
    up_c     = i_up & ~i_down;
    active_c = i_game_run & (right_c | left_c | down_c | up_c);
    // Counter sits at zero whenever the previous cycle was idle, giving the immediate first step.
    move_c   = active_c & (rep_cnt == '0);

    x_ext_c  = {1'b0, o_x};
    x_inc_c  = x_ext_c + XE_W'(STEP);
    x_dec_c  = x_ext_c - XE_W'(STEP);
    x_next_c = o_x;
    if (right_c) begin
      x_next_c = (x_inc_c > XE_W'(X_MAX)) ? X_W'(X_MAX) : x_inc_c[X_W-1:0];
    end else if (left_c) begin
      x_next_c = (x_ext_c < XE_W'(X_MIN + STEP)) ? X_W'(X_MIN) : x_dec_c[X_W-1:0];
    end

    y_ext_c  = {1'b0, o_y};
    y_inc_c  = y_ext_c + YE_W'(STEP);
    y_dec_c  = y_ext_c - YE_W'(STEP);
    y_next_c = o_y;
    if (down_c) begin
      y_next_c = (y_inc_c > YE_W'(Y_MAX)) ? Y_W'(Y_MAX) : y_inc_c[Y_W-1:0];
    end else if (up_c) begin
      y_next_c = (y_ext_c < YE_W'(Y_MIN + STEP)) ? Y_W'(Y_MIN) : y_dec_c[Y_W-1:0];
    end
  end

  // Position and auto-repeat counter; respawn wins over a move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_x      <= X_W'(X_INIT);
      o_y      <= Y_W'(Y_INIT);
      rep_cnt  <= '0;
      o_moving <= 1'b0;
    end else begin
      o_moving <= active_c;
      if (i_respawn) begin
        o_x     <= X_W'(X_INIT);
        o_y     <= Y_W'(Y_INIT);
        rep_cnt <= '0;
      end else if (!active_c) begin
        rep_cnt <= '0;
      end else if (move_c) begin
        o_x     <= x_next_c;
        o_y     <= y_next_c;
        rep_cnt <= RC_W'(REPEAT_CYC - 1);
      end else begin
        rep_cnt <= rep_cnt - RC_W'(1);
      end
    end
  end

  // Shot FSM; fire pulses outside IDLE are dropped, game stop aborts to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shot_state        <= ST_IDLE;
      shoot.shoot_valid <= 1'b0;
      shoot.shoot_x     <= '0;
      shoot.shoot_y     <= '0;
      o_cooldown        <= 1'b0;
      cool_cnt          <= '0;
    end else begin
      case (shot_state)
        ST_IDLE: begin
          if (i_fire && i_game_run) begin
            shot_state        <= ST_REQ;
            shoot.shoot_valid <= 1'b1;
            shoot.shoot_x     <= o_x;
            shoot.shoot_y     <= o_y;
          end
        end
        ST_REQ: begin
          if (!i_game_run) begin
            shot_state        <= ST_IDLE;
            shoot.shoot_valid <= 1'b0;
          end else if (shoot.shoot_ready) begin
            shot_state        <= ST_COOL;
            shoot.shoot_valid <= 1'b0;
            o_cooldown        <= 1'b1;
            cool_cnt          <= CC_W'(COOLDOWN_CYC - 1);
          end
        end
        ST_COOL: begin
          if (!i_game_run || (cool_cnt == '0)) begin
            shot_state <= ST_IDLE;
            o_cooldown <= 1'b0;
            cool_cnt   <= '0;
          end else begin
            cool_cnt <= cool_cnt - CC_W'(1);
          end
        end
        default: begin
          shot_state        <= ST_IDLE;
          shoot.shoot_valid <= 1'b0;
          o_cooldown        <= 1'b0;
          cool_cnt          <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/joystick_player_ctrl.md
Name: joystick_player_ctrl

Overview:
- Sits directly downstream of the joystick debounce stage; consumes debounced direction levels and the one-cycle fire pulse.
- Produces the player sprite position with auto-repeat movement and screen-edge clamping.
- Issues shoot requests to the bullet manager over a valid/ready handshake, with a post-shot cooldown.
- Output feeds the game FSM and the VGA renderer.

Parameters:
- X_W, 10, width of x coordinate
- Y_W, 9, width of y coordinate
- X_MIN, 0, leftmost legal x
- X_MAX, 639, rightmost legal x
- Y_MIN, 0, topmost legal y
- Y_MAX, 479, bottommost legal y
- X_INIT, 320, x after reset or respawn
- Y_INIT, 400, y after reset or respawn
- STEP, 4, pixels moved per move tick, per axis
- REPEAT_CYC, 250000, cycles between repeated moves while a direction is held (>=2)
- COOLDOWN_CYC, 5000000, cycles in COOL after an accepted shot (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_up, i_down, i_left, i_right  in  1 each  debounced direction levels, 1 = pressed
- i_fire  in  1  one-cycle fire pulse, 1 = fire
- i_game_run  in  1  level from game FSM; 0 freezes movement and blocks shots
- i_respawn  in  1  one-cycle pulse; returns player to init position
- i_shoot_ready  in  1  bullet manager can accept a shot
- o_x  out  X_W  player x
- o_y  out  Y_W  player y
- o_moving  out  1  1 while an effective direction is held and i_game_run = 1
- o_shoot_valid  out  1  shot request
- o_shoot_x  out  X_W  x latched at fire
- o_shoot_y  out  Y_W  y latched at fire
- o_cooldown  out  1  1 while shot FSM is in COOL

Behaviour:
- Clock and reset: single clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - o_x = X_INIT, o_y = Y_INIT.
  - Repeat counter = 0, shot FSM = IDLE.
  - o_moving = o_shoot_valid = o_cooldown = 0.
  - o_shoot_x = o_shoot_y = 0.
- Effective direction:
  - dx = right − left, dy = down − up.
  - Up+down together gives dy = 0; left+right together gives dx = 0.
  - active = i_game_run and (dx ≠ 0 or dy ≠ 0); o_moving = active, registered (1 cycle lag).
- Move timing:
  - First cycle active after a cycle of not-active: move is applied at that clock edge (immediate first step) and the repeat counter is loaded with REPEAT_CYC−1.
  - While active, the counter decrements; when it is 0, move again and reload.
  - When not active, counter is held at 0.
- Move arithmetic:
  - Compute in one extra bit.
  - x_new = x + STEP, clamped to X_MAX; x_new = x − STEP, clamped to X_MIN with no underflow wrap. Same rule for y with Y_MIN/Y_MAX.
  - Axes update independently in the same cycle (diagonal).
  - Already at the bound: position unchanged; counter runs normally.
- Respawn:
  - i_respawn = 1 loads X_INIT/Y_INIT and clears the counter.
  - Has priority over a move in the same cycle.
  - Does not affect the shot FSM.
- Freeze: i_game_run = 0 leaves position unchanged and clears the counter.
- Shot FSM states: IDLE, REQ, COOL.
  - IDLE:
    - i_fire & i_game_run → REQ; o_shoot_valid = 1 from the next cycle.
    - o_shoot_x/o_shoot_y latch the o_x/o_y value present in the fire cycle (pre-move).
  - REQ:
    - o_shoot_valid held high, payload stable until i_shoot_ready = 1 is sampled.
    - On that edge → COOL; cooldown counter = COOLDOWN_CYC−1; valid drops the next cycle.
  - COOL: o_cooldown = 1; counter decrements; at 0 → IDLE.
  - i_fire pulses in REQ or COOL are dropped, not queued.
  - i_game_run = 0 in REQ or COOL → IDLE next cycle; valid and o_cooldown drop, counter cleared.
  - i_fire and i_game_run falling in the same cycle: no request.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Test Plan:
- Bench parameter overrides: REPEAT_CYC = 4, COOLDOWN_CYC = 8, STEP = 4.
- Reset release, i_game_run = 1, i_right held 9 cycles → x steps 320→324 on cycle 1, →328 on cycle 5, →332 on cycle 9; y stays 400; o_moving = 1 from cycle 2.
- Position x = 637, i_right held → x = 639, then stays 639. Position y = 2, i_up held → y = 0; no wrap to 511.
- i_left+i_right+i_down held → x unchanged, y increments by 4 per tick. Up+down alone → no movement, o_moving = 0.
- i_fire pulse at (320,400), i_shoot_ready low 3 cycles then high →
  - o_shoot_valid high 4 cycles with payload (320,400) stable.
  - o_cooldown high 8 cycles.
  - Second i_fire during COOL ignored.
  - Fire after IDLE accepted.
- In REQ, drop i_game_run → valid = 0 next cycle, FSM IDLE. Assert rst_n = 0 mid-COOL → o_cooldown = 0 and position (320,400) with no clock edge required.
- i_respawn coincident with a move tick at (100,50) → position (320,400); shot FSM state unchanged.
